// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, CCR flag layout and the writeback entry payload.
package alu_pkg;

  localparam int unsigned OP_SIZE = 4;
  localparam int unsigned CCR_W   = 4;
  localparam int unsigned DST_W   = 2;

  localparam logic [CCR_W-1:0] C_MASK = 4'b1000;
  localparam logic [CCR_W-1:0] V_MASK = 4'b0100;
  localparam logic [CCR_W-1:0] N_MASK = 4'b0010;
  localparam logic [CCR_W-1:0] Z_MASK = 4'b0001;

  localparam int unsigned C_IDX = 3;
  localparam int unsigned V_IDX = 2;
  localparam int unsigned N_IDX = 1;
  localparam int unsigned Z_IDX = 0;

  typedef struct packed {
    logic [OP_SIZE-1:0] r;
    logic [DST_W-1:0]   dst;
    logic [CCR_W-1:0]   ccr;
  } entry_t;

  // Place individual flag values at their CCR positions.
  function automatic logic [CCR_W-1:0] flag_vec(input logic c, input logic v,
                                                input logic n, input logic z);
    return (c ? C_MASK : '0) | (v ? V_MASK : '0) |
           (n ? N_MASK : '0) | (z ? Z_MASK : '0);
  endfunction

endpackage

// File: rtl/ccr_merge.sv
// Computes N/Z from a result and merges C/V/N/Z into the previous CCR under an update mask.
module ccr_merge
  import alu_pkg::*;
#(
  parameter int unsigned W = OP_SIZE
) (
  input  logic [W-1:0]     r,
  input  logic             c,
  input  logic             v,
  input  logic [CCR_W-1:0] upd,
  input  logic [CCR_W-1:0] prev,
  output logic [CCR_W-1:0] merged_c
);

  logic [CCR_W-1:0] calc_c;

  always_comb begin
    calc_c   = flag_vec(c, v, r[W-1], (r == '0));
    merged_c = (calc_c & upd) | (prev & ~upd);
  end

endmodule

// File: rtl/ccr_writeback.sv
// ALU writeback stage: owns the architectural CCR and buffers two results toward the register file.
module ccr_writeback
  import alu_pkg::*;
#(
  parameter int unsigned op_size = OP_SIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [op_size-1:0] in_r,
  input  logic               in_c,
  input  logic               in_v,
  input  logic [3:0]         in_upd,
  input  logic [1:0]         in_dst,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [op_size-1:0] out_r,
  output logic [1:0]         out_dst,
  output logic [3:0]         out_ccr,
  output logic [3:0]         ccr,
  input  logic               ccr_we,
  input  logic [3:0]         ccr_wdata,
  output logic               ccr_err
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  logic [op_size-1:0] r_q    [DEPTH];
  logic [op_size-1:0] r_d    [DEPTH];
  logic [DST_W-1:0]   dst_q  [DEPTH];
  logic [DST_W-1:0]   dst_d  [DEPTH];
  logic [CCR_W-1:0]   eccr_q [DEPTH];
  logic [CCR_W-1:0]   eccr_d [DEPTH];

  logic               head_q, head_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CCR_W-1:0]   ccr_q, ccr_d;
  logic [CCR_W-1:0]   spec_ccr_q, spec_ccr_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [op_size-1:0] out_r_q, out_r_d;
  logic [DST_W-1:0]   out_dst_q, out_dst_d;
  logic [CCR_W-1:0]   out_ccr_q, out_ccr_d;
  logic               ccr_err_q, ccr_err_d;

  logic               push_c;
  logic               pop_c;
  logic               load_ok_c;
  logic               tail_c;
  logic [CCR_W-1:0]   merged_c;

  // Merge against the CCR as seen by the youngest accepted op, not the committed one.
  ccr_merge #(.W(op_size)) u_merge (
    .r        (in_r),
    .c        (in_c),
    .v        (in_v),
    .upd      (in_upd),
    .prev     (spec_ccr_q),
    .merged_c (merged_c)
  );

  always_comb begin
    push_c     = in_valid && in_ready_q;
    pop_c      = out_valid_q && out_ready;
    load_ok_c  = ccr_we && (count_q == '0) && !push_c;
    // Two entries: head + count modulo 2.
    tail_c     = head_q ^ count_q[0];

    r_d        = r_q;
    dst_d      = dst_q;
    eccr_d     = eccr_q;
    head_d     = head_q;
    ccr_d      = ccr_q;
    spec_ccr_d = spec_ccr_q;

    if (push_c) begin
      r_d[tail_c]    = in_r;
      dst_d[tail_c]  = in_dst;
      eccr_d[tail_c] = merged_c;
      spec_ccr_d     = merged_c;
    end

    if (pop_c) begin
      head_d = ~head_q;
      ccr_d  = eccr_q[head_q];
    end

    if (load_ok_c) begin
      ccr_d      = ccr_wdata;
      spec_ccr_d = ccr_wdata;
    end

    count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    ccr_err_d   = ccr_we && !load_ok_c;
    out_valid_d = (count_d != '0);
    in_ready_d  = (count_d != CNT_W'(DEPTH));
    out_r_d     = r_d[head_d];
    out_dst_d   = dst_d[head_d];
    out_ccr_d   = eccr_d[head_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i]    <= '0;
        dst_q[i]  <= '0;
        eccr_q[i] <= '0;
      end
      head_q      <= 1'b0;
      count_q     <= '0;
      ccr_q       <= '0;
      spec_ccr_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_r_q     <= '0;
      out_dst_q   <= '0;
      out_ccr_q   <= '0;
      ccr_err_q   <= 1'b0;
    end else begin
      r_q         <= r_d;
      dst_q       <= dst_d;
      eccr_q      <= eccr_d;
      head_q      <= head_d;
      count_q     <= count_d;
      ccr_q       <= ccr_d;
      spec_ccr_q  <= spec_ccr_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      out_r_q     <= out_r_d;
      out_dst_q   <= out_dst_d;
      out_ccr_q   <= out_ccr_d;
      ccr_err_q   <= ccr_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_dst   = out_dst_q;
  assign out_ccr   = out_ccr_q;
  assign ccr       = ccr_q;
  assign ccr_err   = ccr_err_q;

endmodule

// File: tb/tb_ccr_writeback.sv
// Bench for ccr_writeback: directed vector table, hand sequences for reset and streaming, random vs queue model.
module tb_ccr_writeback;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_c, in_v;
  logic [3:0] in_r, in_upd;
  logic [1:0] in_dst;
  logic       out_valid, out_ready;
  logic [3:0] out_r, out_ccr, ccr;
  logic [1:0] out_dst;
  logic       ccr_we, ccr_err;
  logic [3:0] ccr_wdata;

  int n_pass = 0;
  int n_total = 0;

  ccr_writeback #(.op_size(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_c(in_c), .in_v(in_v),
    .in_upd(in_upd), .in_dst(in_dst),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_dst(out_dst),
    .out_ccr(out_ccr), .ccr(ccr), .ccr_we(ccr_we), .ccr_wdata(ccr_wdata), .ccr_err(ccr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       iv;
    logic [3:0] r;
    logic       c;
    logic       v;
    logic [3:0] upd;
    logic [1:0] dst;
    logic       ordy;
    logic       we;
    logic [3:0] wd;
    logic       e_valid;
    logic       e_ready;
    logic [3:0] e_r;
    logic [1:0] e_dst;
    logic [3:0] e_occr;
    logic [3:0] e_ccr;
    logic       e_err;
  } vec_t;

  typedef struct {
    logic [3:0] r;
    logic [1:0] dst;
    logic [3:0] ccr;
  } ent_t;

  // Reference state: queue of buffered ops plus committed and speculative CCR.
  ent_t       mq[$];
  logic [3:0] m_ccr, m_spec;
  logic       m_err;

  vec_t tbl[20];

  function automatic vec_t row(logic iv, logic [3:0] r, logic c, logic v, logic [3:0] upd,
                               logic [1:0] dst, logic ordy, logic we, logic [3:0] wd,
                               logic ev, logic erdy, logic [3:0] er, logic [1:0] edst,
                               logic [3:0] eoccr, logic [3:0] eccr, logic eerr);
    vec_t x;
    x.iv = iv; x.r = r; x.c = c; x.v = v; x.upd = upd; x.dst = dst;
    x.ordy = ordy; x.we = we; x.wd = wd;
    x.e_valid = ev; x.e_ready = erdy; x.e_r = er; x.e_dst = edst;
    x.e_occr = eoccr; x.e_ccr = eccr; x.e_err = eerr;
    return x;
  endfunction

  function automatic vec_t idle(logic ordy);
    return row(0, 0, 0, 0, 0, 0, ordy, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t pushv(logic [3:0] r, logic c, logic v, logic [3:0] upd,
                                 logic [1:0] dst, logic ordy);
    return row(1, r, c, v, upd, dst, ordy, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [3:0] ref_merge(logic [3:0] prev, logic [3:0] r, logic c, logic v,
                                           logic [3:0] upd);
    logic [3:0] m;
    m[3] = upd[3] ? c : prev[3];
    m[2] = upd[2] ? v : prev[2];
    m[1] = upd[1] ? r[3] : prev[1];
    m[0] = upd[0] ? (r == 4'd0) : prev[0];
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ccr = 4'h0;
    m_spec = 4'h0;
    m_err = 1'b0;
  endtask

  task automatic model_edge(input vec_t x);
    bit   push, pop, load;
    ent_t e;
    push = x.iv && (mq.size() < 2);
    pop  = (mq.size() > 0) && x.ordy;
    load = x.we && (mq.size() == 0) && !push;
    e.r = x.r;
    e.dst = x.dst;
    e.ccr = ref_merge(m_spec, x.r, x.c, x.v, x.upd);
    m_err = x.we && !load;
    if (pop) begin
      m_ccr = mq[0].ccr;
      void'(mq.pop_front());
    end
    if (push) begin
      mq.push_back(e);
      m_spec = e.ccr;
    end
    if (load) begin
      m_ccr = x.wd;
      m_spec = x.wd;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input vec_t x);
    in_valid = x.iv; in_r = x.r; in_c = x.c; in_v = x.v; in_upd = x.upd; in_dst = x.dst;
    out_ready = x.ordy; ccr_we = x.we; ccr_wdata = x.wd;
    @(posedge clk);
    model_edge(x);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " out_valid"}, 8'(out_valid), 8'(mq.size() != 0));
    chk({tag, " in_ready"}, 8'(in_ready), 8'(mq.size() < 2));
    chk({tag, " ccr"}, 8'(ccr), 8'(m_ccr));
    chk({tag, " ccr_err"}, 8'(ccr_err), 8'(m_err));
    if (mq.size() != 0) begin
      chk({tag, " out_r"}, 8'(out_r), 8'(mq[0].r));
      chk({tag, " out_dst"}, 8'(out_dst), 8'(mq[0].dst));
      chk({tag, " out_ccr"}, 8'(out_ccr), 8'(mq[0].ccr));
    end
  endtask

  initial begin
    //            iv r      c  v  upd     d  ordy we wd     | ev rdy r      d  occr    ccr     err
    tbl[0]  = row(0, 4'h0,  0, 0, 4'b0000, 0, 0, 1, 4'b1100, 0, 1, 4'h0, 0, 4'b0000, 4'b1100, 0);
    tbl[1]  = row(1, 4'h0,  0, 0, 4'b0011, 1, 0, 0, 4'b0000, 1, 1, 4'h0, 1, 4'b1101, 4'b1100, 0);
    tbl[2]  = row(0, 4'h0,  0, 0, 4'b0000, 0, 1, 0, 4'b0000, 0, 1, 4'h0, 0, 4'b0000, 4'b1101, 0);
    tbl[3]  = row(1, 4'hA,  0, 0, 4'b0011, 2, 0, 0, 4'b0000, 1, 1, 4'hA, 2, 4'b1110, 4'b1101, 0);
    tbl[4]  = row(0, 4'h0,  0, 0, 4'b0000, 0, 1, 0, 4'b0000, 0, 1, 4'h0, 0, 4'b0000, 4'b1110, 0);
    tbl[5]  = row(0, 4'h0,  0, 0, 4'b0000, 0, 0, 1, 4'b0000, 0, 1, 4'h0, 0, 4'b0000, 4'b0000, 0);
    tbl[6]  = row(1, 4'h7,  1, 1, 4'b1111, 3, 0, 0, 4'b0000, 1, 1, 4'h7, 3, 4'b1100, 4'b0000, 0);
    tbl[7]  = row(1, 4'h8,  0, 0, 4'b0011, 0, 0, 0, 4'b0000, 1, 0, 4'h7, 3, 4'b1100, 4'b0000, 0);
    tbl[8]  = row(1, 4'h1,  0, 0, 4'b1111, 1, 0, 0, 4'b0000, 1, 0, 4'h7, 3, 4'b1100, 4'b0000, 0);
    tbl[9]  = row(0, 4'h0,  0, 0, 4'b0000, 0, 0, 1, 4'b1111, 1, 0, 4'h7, 3, 4'b1100, 4'b0000, 1);
    tbl[10] = row(0, 4'h0,  0, 0, 4'b0000, 0, 0, 0, 4'b0000, 1, 0, 4'h7, 3, 4'b1100, 4'b0000, 0);
    tbl[11] = row(0, 4'h0,  0, 0, 4'b0000, 0, 1, 0, 4'b0000, 1, 1, 4'h8, 0, 4'b1110, 4'b1100, 0);
    tbl[12] = row(0, 4'h0,  0, 0, 4'b0000, 0, 1, 0, 4'b0000, 0, 1, 4'h0, 0, 4'b0000, 4'b1110, 0);
    tbl[13] = row(0, 4'h0,  0, 0, 4'b0000, 0, 0, 1, 4'b1111, 0, 1, 4'h0, 0, 4'b0000, 4'b1111, 0);
    tbl[14] = row(1, 4'h0,  0, 0, 4'b0000, 2, 0, 0, 4'b0000, 1, 1, 4'h0, 2, 4'b1111, 4'b1111, 0);
    tbl[15] = row(0, 4'h0,  0, 0, 4'b0000, 0, 0, 1, 4'b0000, 1, 1, 4'h0, 2, 4'b1111, 4'b1111, 1);
    tbl[16] = row(0, 4'h0,  0, 0, 4'b0000, 0, 0, 0, 4'b0000, 1, 1, 4'h0, 2, 4'b1111, 4'b1111, 0);
    tbl[17] = row(0, 4'h0,  0, 0, 4'b0000, 0, 1, 0, 4'b0000, 0, 1, 4'h0, 0, 4'b0000, 4'b1111, 0);
    tbl[18] = row(1, 4'h5,  0, 0, 4'b0000, 1, 0, 1, 4'b0000, 1, 1, 4'h5, 1, 4'b1111, 4'b1111, 1);
    tbl[19] = row(0, 4'h0,  0, 0, 4'b0000, 0, 1, 0, 4'b0000, 0, 1, 4'h0, 0, 4'b0000, 4'b1111, 0);

    rst = 1'b1;
    in_valid = 0; in_r = 0; in_c = 0; in_v = 0; in_upd = 0; in_dst = 0;
    out_ready = 0; ccr_we = 0; ccr_wdata = 0;
    model_reset();
    #12;
    chk("reset out_valid", 8'(out_valid), 8'h0);
    chk("reset in_ready", 8'(in_ready), 8'h1);
    chk("reset out_r", 8'(out_r), 8'h0);
    chk("reset out_dst", 8'(out_dst), 8'h0);
    chk("reset out_ccr", 8'(out_ccr), 8'h0);
    chk("reset ccr", 8'(ccr), 8'h0);
    chk("reset ccr_err", 8'(ccr_err), 8'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-derived expectations.
    for (int i = 0; i < 20; i++) begin
      step(tbl[i]);
      chk($sformatf("row%0d out_valid", i), 8'(out_valid), 8'(tbl[i].e_valid));
      chk($sformatf("row%0d in_ready", i), 8'(in_ready), 8'(tbl[i].e_ready));
      chk($sformatf("row%0d ccr", i), 8'(ccr), 8'(tbl[i].e_ccr));
      chk($sformatf("row%0d ccr_err", i), 8'(ccr_err), 8'(tbl[i].e_err));
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d out_r", i), 8'(out_r), 8'(tbl[i].e_r));
        chk($sformatf("row%0d out_dst", i), 8'(out_dst), 8'(tbl[i].e_dst));
        chk($sformatf("row%0d out_ccr", i), 8'(out_ccr), 8'(tbl[i].e_occr));
      end
    end

    // Asynchronous reset with a full buffer, asserted between clock edges.
    step(pushv(4'h3, 0, 0, 4'b0011, 1, 0));
    step(pushv(4'h9, 1, 0, 4'b1111, 2, 0));
    check_model("prereset");
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async out_valid", 8'(out_valid), 8'h0);
    chk("async ccr", 8'(ccr), 8'h0);
    chk("async out_ccr", 8'(out_ccr), 8'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(idle(1));
      check_model($sformatf("postreset%0d", i));
    end

    // Streaming push and pop every cycle holds one entry in flight.
    for (int k = 1; k <= 6; k++) begin
      step(pushv(4'(k), 0, 0, 4'b0011, 2'(k), 1));
      chk($sformatf("stream%0d out_valid", k), 8'(out_valid), 8'h1);
      chk($sformatf("stream%0d in_ready", k), 8'(in_ready), 8'h1);
      chk($sformatf("stream%0d out_r", k), 8'(out_r), 8'(k));
    end
    step(idle(1));
    chk("stream drain out_valid", 8'(out_valid), 8'h0);
    check_model("stream drain");

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      vec_t x;
      x = row($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom), 1'($urandom),
              4'($urandom), 2'($urandom), $urandom_range(0, 2) != 0,
              $urandom_range(0, 7) == 0, 4'($urandom), 0, 0, 0, 0, 0, 0, 0);
      step(x);
      check_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
